dmem_responder: RTL and testbench

//  Memory-side responder for the CPU data-memory request interface. Accepts one

---
 rtl/mem_if_pkg.sv | 19 +
 rtl/sram_1rw.sv | 34 +++
 rtl/dmem_responder.sv | 159 +++++++++++++++
 tb/tb_dmem_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared types and constants for the data-memory request interface
//
// Contents:
//   WORD_W      data word width
//   ALIGN_MASK  byte-offset bits that must be zero for a word-aligned address
//   state_t     responder FSM state encoding (IDLE/WAIT/RESP)
package mem_if_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/sram_1rw.sv
// rtl/sram_1rw.sv - single-port synchronous RAM with registered read
//
// Ports:
//   clk    in   rising-edge clock
//   en     in   port enable; nothing happens while low
//   we     in   1 = write wdata to addr, 0 = read addr into rdata
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data; holds its value until the next read
module sram_1rw #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: request latch, wait states, error decode, RAM
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high
//   req_valid   in   initiator presents a request
//   req_ready   out  responder accepts a request this cycle (IDLE only)
//   req_write   in   1 = write, 0 = read
//   req_addr    in   byte address, must be word aligned
//   req_wdata   in   write data
//   resp_valid  out  response present, held until resp_ready
//   resp_ready  in   initiator accepts the response
//   resp_rdata  out  read data (0 for writes and errors)
//   resp_err    out  misaligned or out-of-range request
module dmem_responder
    import mem_if_pkg::*;
#(
    parameter int                DEPTH_WORDS = 1024,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        wait_cnt_q;
    logic              lat_write_q;
    logic [ADDR_W-1:0] lat_addr_q;
    logic [WORD_W-1:0] lat_wdata_q;
    logic              resp_err_q;
    logic              resp_rd_q;

    logic              accept;
    logic              resp_hs;
    logic              last_wait;
    logic              commit;
    logic              op_write;
    logic [ADDR_W-1:0] op_addr;
    logic [ADDR_W-1:0] op_offset;
    logic [WORD_W-1:0] op_wdata;
    logic              op_err;
    logic              ram_en;
    logic [WORD_W-1:0] ram_rdata;

    assign accept    = req_valid && req_ready;
    assign resp_hs   = resp_valid && resp_ready;
    assign last_wait = (wait_cnt_q == LAST_WAIT);

    // With zero wait states the commit edge is the accept edge itself, so the
    // operands must bypass the latch and come straight from req_*.
    assign op_write  = (state_q == ST_IDLE) ? req_write : lat_write_q;
    assign op_addr   = (state_q == ST_IDLE) ? req_addr  : lat_addr_q;
    assign op_wdata  = (state_q == ST_IDLE) ? req_wdata : lat_wdata_q;

    // Unsigned ADDR_W-wide arithmetic; the below-base test guards the wrap of op_offset.
    assign op_offset = op_addr - BASE_ADDR;
    assign op_err    = ((op_addr[1:0] & ALIGN_MASK) != 2'b00)
                    || (op_addr < BASE_ADDR)
                    || ({2'b00, op_offset[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS));

    assign commit = ((state_q == ST_WAIT) && last_wait)
                 || ((state_q == ST_IDLE) && accept && (WAIT_CYCLES == 0));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (last_wait) state_d = ST_RESP;
            ST_RESP: if (resp_hs)   state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Outputs; RAM access is suppressed under reset so a write dropped by
    // reset in its final wait cycle never reaches the array.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        ram_en     = 1'b0;
        case (state_q)
            ST_IDLE: req_ready  = !reset;
            ST_RESP: resp_valid = 1'b1;
            default: ;
        endcase
        if (commit && !op_err && !reset) begin
            ram_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            resp_err_q <= 1'b0;
            resp_rd_q  <= 1'b0;
        end else begin
            if ((state_q == ST_WAIT) && !last_wait) begin
                wait_cnt_q <= wait_cnt_q + 4'd1;
            end else begin
                wait_cnt_q <= '0;
            end
            if (commit) begin
                resp_err_q <= op_err;
                resp_rd_q  <= !op_write && !op_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write_q <= req_write;
            lat_addr_q  <= req_addr;
            lat_wdata_q <= req_wdata;
        end
    end

    sram_1rw #(
        .DEPTH (DEPTH_WORDS),
        .WIDTH (WORD_W)
    ) u_sram (
        .clk   (clk),
        .en    (ram_en),
        .we    (op_write),
        .addr  (op_offset[IDX_W+1:2]),
        .wdata (op_wdata),
        .rdata (ram_rdata)
    );

    // The RAM read register only changes on a read commit, so gating it with
    // the captured "was a good read" flag keeps resp_rdata stable and zero
    // for writes and errors.
    assign resp_rdata = resp_rd_q ? ram_rdata : '0;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (three wait-state configurations)
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset      [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [int];
    logic [32:0] exp_q [$];

    always #5 clk = !clk;

    // Instance 0: WAIT=1, 1024 words at 0. Instance 1: WAIT=3, same map.
    // Instance 2: WAIT=0, 16 words at 0x100.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS ((g == 2) ? 16 : 1024),
            .ADDR_W      (32),
            .BASE_ADDR   ((g == 2) ? 32'h100 : 32'h0),
            .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 3 : 0))
        ) u_dut (
            .clk        (clk),
            .reset      (reset[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    function automatic int wc(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    function automatic logic [31:0] base_of(input int k);
        return (k == 2) ? 32'h100 : 32'h0;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 2) ? 16 : 1024;
    endfunction

    // Reference model: memory as a sparse array, rules straight from the interface definition.
    function automatic void model(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                                  output bit err, output logic [31:0] rd, output bit known);
        longint unsigned idx;
        err   = (a % 4 != 0) || (a < base_of(k)) || (((a - base_of(k)) / 4) >= depth_of(k));
        rd    = 32'h0;
        known = 1'b1;
        if (!err) begin
            idx = k * 65536 + (a - base_of(k)) / 4;
            if (w) begin
                mem_m[int'(idx)] = d;
            end else if (mem_m.exists(int'(idx))) begin
                rd = mem_m[int'(idx)];
            end else begin
                known = 1'b0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete transaction with bp cycles of back-pressure on the response.
    task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d, input int bp);
        bit          e_exp;
        bit          known;
        logic [31:0] rd_exp;
        int          lat;
        model(k, w, a, d, e_exp, rd_exp, known);
        chk($sformatf("req_ready_idle[%0d]", k), req_ready[k], 1'b1);
        req_valid[k] = 1'b1;
        req_write[k] = w;
        req_addr[k]  = a;
        req_wdata[k] = d;
        tick();
        req_valid[k] = 1'b0;
        req_write[k] = 1'($urandom_range(0, 1));
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        lat = 1;
        while (resp_valid[k] !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk($sformatf("latency[%0d] a=%h", k, a), 32'(lat), 32'(wc(k) + 1));
        chk($sformatf("resp_err[%0d] a=%h", k, a), resp_err[k], e_exp);
        if (known) chk($sformatf("resp_rdata[%0d] a=%h", k, a), resp_rdata[k], rd_exp);
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("bp_valid", resp_valid[k], 1'b1);
            chk("bp_req_ready", req_ready[k], 1'b0);
            chk("bp_err", resp_err[k], e_exp);
            if (known) chk("bp_rdata", resp_rdata[k], rd_exp);
        end
        resp_ready[k] = 1'b1;
        tick();
        resp_ready[k] = 1'b0;
        chk($sformatf("valid_after_hs[%0d]", k), resp_valid[k], 1'b0);
        chk($sformatf("ready_after_hs[%0d]", k), req_ready[k], 1'b1);
    endtask

    function automatic logic [31:0] pick_addr(input int k);
        int kind;
        kind = $urandom_range(0, 9);
        case (kind)
            0:       return base_of(k) + 4 * $urandom_range(0, 7) + $urandom_range(1, 3);
            1:       return base_of(k) + 4 * depth_of(k) + 4 * $urandom_range(0, 3);
            2:       return (k == 2) ? 32'h100 - 4 * $urandom_range(1, 8) : 32'h4 * $urandom_range(0, 7);
            default: return base_of(k) + 4 * $urandom_range(0, (k == 2) ? 15 : 7);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          e_exp;
        bit          known;
        logic [31:0] rd_exp;
        logic [31:0] a;
        logic [32:0] ent;

        for (int k = 0; k < 3; k++) begin
            reset[k]      = 1'b1;
            req_valid[k]  = 1'b0;
            req_write[k]  = 1'b0;
            req_addr[k]   = 32'h0;
            req_wdata[k]  = 32'h0;
            resp_ready[k] = 1'b0;
        end

        // Reset state
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_req_ready[%0d]", k), req_ready[k], 1'b0);
            chk($sformatf("rst_resp_valid[%0d]", k), resp_valid[k], 1'b0);
            chk($sformatf("rst_resp_rdata[%0d]", k), resp_rdata[k], 32'h0);
            chk($sformatf("rst_resp_err[%0d]", k), resp_err[k], 1'b0);
            reset[k] = 1'b0;
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("post_rst_ready[%0d]", k), req_ready[k], 1'b1);
            chk($sformatf("post_rst_valid[%0d]", k), resp_valid[k], 1'b0);
        end
        repeat (4) begin
            tick();
            chk("idle_ready", req_ready[0], 1'b1);
            chk("idle_valid", resp_valid[0], 1'b0);
        end

        // WAIT=1: basic write/read, back-pressured read, errors
        txn(0, 1'b1, 32'h0,  32'hA5A5_0000, 0);
        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 5);
        txn(0, 1'b0, 32'h13, 32'h0, 0);
        txn(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 1);
        txn(0, 1'b0, 32'h0,  32'h0, 0);
        for (int i = 0; i < 24; i++) begin
            txn(0, 1'($urandom_range(0, 1)), pick_addr(0), $urandom, $urandom_range(0, 2));
        end

        // WAIT=3: reset in the second wait cycle drops a pending write
        txn(1, 1'b1, 32'h20, 32'h5555_AAAA, 0);
        chk("midwait_ready", req_ready[1], 1'b1);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = 32'h20;
        req_wdata[1] = 32'h0000_1234;
        tick();
        req_valid[1] = 1'b0;
        chk("midwait_valid_w1", resp_valid[1], 1'b0);
        tick();
        reset[1] = 1'b1;
        tick();
        chk("midwait_rst_ready", req_ready[1], 1'b0);
        chk("midwait_rst_valid", resp_valid[1], 1'b0);
        reset[1] = 1'b0;
        repeat (6) begin
            tick();
            chk("midwait_no_resp", resp_valid[1], 1'b0);
        end
        chk("midwait_ready_after", req_ready[1], 1'b1);
        txn(1, 1'b0, 32'h20, 32'h0, 2);
        for (int i = 0; i < 8; i++) begin
            txn(1, 1'($urandom_range(0, 1)), pick_addr(1), $urandom, $urandom_range(0, 1));
        end

        // WAIT=0: preload, random single transactions, then streaming reads
        for (int i = 0; i < 16; i++) begin
            txn(2, 1'b1, 32'h100 + 4 * i, $urandom, 0);
        end
        for (int i = 0; i < 16; i++) begin
            txn(2, 1'($urandom_range(0, 1)), pick_addr(2), $urandom, $urandom_range(0, 1));
        end
        resp_ready[2] = 1'b1;
        req_valid[2]  = 1'b1;
        req_write[2]  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c % 2 == 0) begin
                a = pick_addr(2);
                req_addr[2] = a;
                model(2, 1'b0, a, 32'h0, e_exp, rd_exp, known);
                exp_q.push_back({e_exp, rd_exp});
                chk($sformatf("stream_ready c=%0d", c), req_ready[2], 1'b1);
                chk($sformatf("stream_valid c=%0d", c), resp_valid[2], 1'b0);
            end else begin
                chk($sformatf("stream_ready c=%0d", c), req_ready[2], 1'b0);
                chk($sformatf("stream_valid c=%0d", c), resp_valid[2], 1'b1);
                if (exp_q.size() > 0) begin
                    ent = exp_q.pop_front();
                    chk($sformatf("stream_err c=%0d", c), resp_err[2], ent[32]);
                    chk($sformatf("stream_rdata c=%0d", c), resp_rdata[2], ent[31:0]);
                end
            end
            tick();
        end
        req_valid[2]  = 1'b0;
        resp_ready[2] = 1'b0;
        chk("stream_end_ready", req_ready[2], 1'b1);
        chk("stream_end_valid", resp_valid[2], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
